parallel_cpu_2_cpu_debug_ocimem: RTL and testbench
==================================================

# parallel_cpu_2_cpu_debug_ocimem

On-chip debug monitor memory for cpu_2, directly downstream of the debug-slave JTAG wrapper. It consumes `jdo` and the `take_action_ocimem_*` strobes from the sysclk stage, and returns `MonDReg`, `monitor_ready` and `monitor_error` to that wrapper. It also presents a 256-word monitor RAM and a status register to the CPU as an Avalon-MM debug slave. JTAG and CPU share one single-port synchronous RAM through a small arbitration FSM.

## Interface
- `ADDR_W`, 8: monitor RAM word-address width (256 × 32).
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `jdo`  in  38  JTAG data-out from the sysclk stage.
- `take_action_ocimem_a`  in  1  single-cycle pulse: load address, clear monitor flags.
- `take_action_ocimem_b`  in  1  single-cycle pulse: JTAG write word.
- `take_no_action_ocimem_a`  in  1  single-cycle pulse: JTAG read word.
- `address`  in  9  Avalon word address; bit 8 = 0 selects RAM, bit 8 = 1 selects the register space.
- `read`, `write`  in  1  Avalon strobes, held until `waitrequest` = 0.
- `writedata`  in  32  Avalon write data.
- `byteenable`  in  4  Avalon byte enables.
- `debugaccess`  in  1  must be 1 for CPU writes to RAM to take effect.
- `readdata`  out  32  registered read data.
- `waitrequest`  out  1  Avalon stall.
- `MonDReg`  out  32  JTAG read-back data register.
- `monitor_ready`, `monitor_error`  out  1  monitor handshake flags.

## Operation
- JTAG decode:
  - `take_action_ocimem_a`: MonAReg ← `jdo[17:10]`; clears `monitor_ready` and `monitor_error`.
  - `take_action_ocimem_b`: RAM[MonAReg] ← `jdo[34:3]`, all bytes written; MonAReg += 1.
  - `take_no_action_ocimem_a`: reads RAM[MonAReg] into MonDReg; MonAReg += 1.
- MonAReg is 8 bits and wraps 0xFF → 0x00.
- JTAG strobes are never stalled. They have absolute priority on the RAM port and are guaranteed at least 3 cycles apart.
- A one-cycle `jrd_pend` flag marks a JTAG read in flight. In the cycle after the read strobe, the RAM output is captured into MonDReg.
- Avalon FSM:
  - IDLE: when (`read` | `write`) and no JTAG strobe, present `address[7:0]` to the RAM and go to ACCESS.
  - ACCESS:
    - If a JTAG strobe is present, stay in ACCESS and re-present the address next cycle.
    - Otherwise, perform the write if `write` (RAM space: `byteenable`-masked, only when `debugaccess` = 1; register space: status update), capture `readdata` if `read`, and go to DONE.
  - DONE: `waitrequest` = 0 for exactly one cycle, then go to IDLE.
- `waitrequest` = 1 in every state except DONE.
- Register space:
  - 0x100 read returns {30'b0, `monitor_error`, `monitor_ready`}.
  - 0x100 write: bit0 = 1 sets ready, bit1 = 1 sets error; zeros have no effect.
  - 0x101–0x1FF read 0; writes are ignored.
- Flag set and clear can never coincide, because the FSM does not complete in a JTAG-strobe cycle.
- `readdata` holds its value until the next completed read. Writes leave it unchanged.

## Timing
- Reset values:
  - MonAReg = 0, MonDReg = 0, `readdata` = 0.
  - `monitor_ready` = 0, `monitor_error` = 0.
  - FSM = IDLE, `waitrequest` = 1.
- Reset asserted mid-access aborts the access. No RAM write occurs after the asserting edge, and RAM contents are not cleared.
- JTAG write strobe at cycle T: RAM updated at the T edge; MonAReg incremented at T+1.
- JTAG read strobe at cycle T: RAM address is registered at T; MonDReg is valid from cycle T+2; MonAReg is incremented from T+1.
- Avalon access with `read`/`write` first seen at cycle N, no contention: `waitrequest` = 0 and `readdata` valid in cycle N+2. Total 3 cycles.
- Each JTAG strobe colliding with IDLE or ACCESS adds exactly one cycle.
- A CPU read immediately after a JTAG write to the same word returns the new data.

## Test plan
- Reset mid-operation: assert `reset_n` = 0 during ACCESS of a RAM write → all outputs at reset values, RAM word unchanged, `waitrequest` = 1.
- JTAG burst: `take_action_ocimem_a` with `jdo[17:10]` = 0xFE, then write strobes with `jdo[34:3]` = 0x11111111 and then 0x22222222 → RAM[0xFE] = 0x11111111, RAM[0xFF] = 0x22222222, MonAReg = 0x00 (wrap). Two read strobes after reloading 0xFE → MonDReg = 0x11111111, then 0x22222222.
- CPU write/read: write 0xA5A5A5A5 to address 0x010 with `byteenable` = 4'b0011, `debugaccess` = 1, over prior content 0xFFFFFFFF, then read → `readdata` = 0xFFFFA5A5, with `waitrequest` low exactly in the third cycle of each access.
- Protection: CPU write with `debugaccess` = 0 → RAM unchanged, access still completes in 3 cycles.
- Contention: JTAG strobe in the CPU's ACCESS cycle → CPU access completes in 4 cycles with correct data; the JTAG operation is also correct.
- Status register: CPU writes 0x3 to 0x100 → `monitor_ready` = 1, `monitor_error` = 1, and a read of 0x100 returns 0x00000003. A subsequent `take_action_ocimem_a` clears both flags to 0.

Source files
------------

// File: rtl/parallel_cpu_2_cpu_debug_ocimem_if.sv
// Avalon-MM debug-slave bundle for the cpu_2 OCI monitor memory.
// master drives address/read/write/writedata/byteenable/debugaccess; slave returns readdata/waitrequest.
interface parallel_cpu_2_cpu_debug_ocimem_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W:0] address;
  logic            read;
  logic            write;
  logic [31:0]     writedata;
  logic [3:0]      byteenable;
  logic            debugaccess;
  logic [31:0]     readdata;
  logic            waitrequest;

  modport master (
    output address, read, write,
    output writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );
endinterface

// File: rtl/parallel_cpu_2_cpu_debug_ocimem.sv
// cpu_2 debug monitor RAM (256x32) + status reg, shared by JTAG strobes and an Avalon slave.
// Ports: clk, reset_n, avl (Avalon slave), jdo/take_* (JTAG), MonDReg, monitor_ready/error.
module parallel_cpu_2_cpu_debug_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  parallel_cpu_2_cpu_debug_ocimem_if.slave avl,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              wait_q, wait_d;
  logic              jrd_pend_q;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       ram_q;
  logic [31:0]       ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              ram_we;

  logic jtag_hit;
  logic avl_req;
  logic reg_sel;
  logic stat_sel;
  logic do_xfer;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign jtag_hit = take_action_ocimem_a
                  | take_action_ocimem_b
                  | take_no_action_ocimem_a;
  assign avl_req  = avl.read | avl.write;
  assign reg_sel  = avl.address[ADDR_W];
  assign stat_sel = reg_sel
                  && (avl.address[ADDR_W-1:0] == '0);
  assign do_xfer  = (state_q == S_ACCESS) && !jtag_hit;

  // JTAG owns the port whenever it strobes.
  assign ram_addr  = jtag_hit ? mon_a_q
                              : avl.address[ADDR_W-1:0];
  assign ram_wdata = take_action_ocimem_b ? jdo[34:3]
                                          : avl.writedata;
  assign ram_be    = take_action_ocimem_b ? 4'hF
                                          : avl.byteenable;
  // reset_n gate: nothing lands in RAM while held in reset.
  assign ram_we    = reset_n
                   && (take_action_ocimem_b
                       || (do_xfer && avl.write
                           && !reg_sel
                           && avl.debugaccess));
  assign ram_rd    = mem[ram_addr];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) begin
          mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
      end
    end
    ram_q <= ram_rd;
  end

  always_comb begin
    state_d = state_q;
    mon_a_d = mon_a_q;
    mon_d_d = mon_d_q;
    rdata_d = rdata_q;
    rdy_d   = rdy_q;
    err_d   = err_q;

    if (take_action_ocimem_a) begin
      mon_a_d = jdo[10 +: ADDR_W];
      rdy_d   = 1'b0;
      err_d   = 1'b0;
    end else if (take_action_ocimem_b
                 || take_no_action_ocimem_a) begin
      mon_a_d = mon_a_q + 1'b1;
    end

    if (jrd_pend_q) begin
      mon_d_d = ram_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (avl_req && !jtag_hit) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!jtag_hit) begin
          state_d = S_DONE;
          if (avl.write && stat_sel) begin
            if (avl.writedata[0]) rdy_d = 1'b1;
            if (avl.writedata[1]) err_d = 1'b1;
          end
          // RAM read uses this cycle's address so a
          // JTAG stall costs only one cycle.
          if (avl.read) begin
            if (!reg_sel) begin
              rdata_d = ram_rd;
            end else if (stat_sel) begin
              rdata_d = {30'b0, err_q, rdy_q};
            end else begin
              rdata_d = '0;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wait_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      rdata_q    <= '0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= 1'b1;
      jrd_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      rdata_q    <= rdata_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      jrd_pend_q <= take_no_action_ocimem_a;
    end
  end

  assign avl.readdata    = rdata_q;
  assign avl.waitrequest = wait_q;
  assign MonDReg         = mon_d_q;
  assign monitor_ready   = rdy_q;
  assign monitor_error   = err_q;

endmodule

// File: tb/tb_parallel_cpu_2_cpu_debug_ocimem.sv
// Self-checking bench for parallel_cpu_2_cpu_debug_ocimem.
// Directed table, hand-written corner sequences, random ops against a reference model.
module tb_parallel_cpu_2_cpu_debug_ocimem;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0;
  logic        ta_b = 1'b0;
  logic        tn_a = 1'b0;
  logic [31:0] mon_d;
  logic        mon_rdy;
  logic        mon_err;

  parallel_cpu_2_cpu_debug_ocimem_if #(.ADDR_W(AW)) avl ();

  parallel_cpu_2_cpu_debug_ocimem #(.ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .avl                     (avl),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tn_a),
    .MonDReg                 (mon_d),
    .monitor_ready           (mon_rdy),
    .monitor_error           (mon_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [31:0] ref_mem [256];
  int          ref_ptr = 0;
  logic        ref_rdy = 1'b0;
  logic        ref_err = 1'b0;
  logic [31:0] ref_mond = '0;
  logic [31:0] ref_rdata = '0;

  localparam int J_LOAD = 0;
  localparam int J_WR   = 1;
  localparam int J_RD   = 2;

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          dbg;
    logic [31:0] exp_rd;
    logic [1:0]  exp_flags;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic m_jtag(input int kind,
                        input logic [31:0] v);
    if (kind == J_LOAD) begin
      ref_ptr = int'(v[7:0]);
      ref_rdy = 1'b0;
      ref_err = 1'b0;
    end else if (kind == J_WR) begin
      ref_mem[ref_ptr] = v;
      ref_ptr = (ref_ptr + 1) % 256;
    end else begin
      ref_mond = ref_mem[ref_ptr];
      ref_ptr = (ref_ptr + 1) % 256;
    end
  endtask

  task automatic m_avl(input bit wr,
                       input logic [8:0] a,
                       input logic [31:0] wd,
                       input logic [3:0] be,
                       input bit dbg);
    if (wr) begin
      if (!a[8]) begin
        if (dbg) begin
          for (int i = 0; i < 4; i++)
            if (be[i])
              ref_mem[a[7:0]][8*i +: 8] = wd[8*i +: 8];
        end
      end else if (a == 9'h100) begin
        ref_rdy = ref_rdy | wd[0];
        ref_err = ref_err | wd[1];
      end
    end else begin
      if (!a[8])
        ref_rdata = ref_mem[a[7:0]];
      else if (a == 9'h100)
        ref_rdata = {30'b0, ref_err, ref_rdy};
      else
        ref_rdata = '0;
    end
  endtask

  task automatic jtag_drive(input int kind,
                            input logic [31:0] v);
    jdo = {6'($urandom), $urandom};
    if (kind == J_LOAD) jdo[17:10] = v[7:0];
    if (kind == J_WR) jdo[34:3] = v;
    ta_a = (kind == J_LOAD);
    ta_b = (kind == J_WR);
    tn_a = (kind == J_RD);
  endtask

  task automatic jtag_clear();
    ta_a = 1'b0;
    ta_b = 1'b0;
    tn_a = 1'b0;
  endtask

  // strobe in cycle T; returns at start of T+2
  task automatic jtag_op(input int kind,
                         input logic [31:0] v);
    @(negedge clk);
    jtag_drive(kind, v);
    m_jtag(kind, v);
    @(negedge clk);
    jtag_clear();
    @(negedge clk);
  endtask

  // jat: cycle (1 = first seen) carrying a JTAG strobe, 0 = none
  task automatic avl_op(input bit wr,
                        input logic [8:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] be,
                        input bit dbg,
                        input int jk,
                        input int jat,
                        input logic [31:0] jv,
                        output int lat,
                        output logic [31:0] rd);
    @(negedge clk);
    avl.address     = a;
    avl.write       = wr;
    avl.read        = !wr;
    avl.writedata   = wd;
    avl.byteenable  = be;
    avl.debugaccess = dbg;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == jat) jtag_drive(jk, jv);
      else jtag_clear();
      if (avl.waitrequest == 1'b0) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    rd = avl.readdata;
    if (jat != 0) m_jtag(jk, jv);
    m_avl(wr, a, wd, be, dbg);
    @(negedge clk);
    avl.read  = 1'b0;
    avl.write = 1'b0;
    jtag_clear();
    chk("wait_after_done",
        32'(avl.waitrequest), 32'd1);
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".MonDReg"}, mon_d, ref_mond);
    chk({tag, ".ready"}, 32'(mon_rdy), 32'(ref_rdy));
    chk({tag, ".error"}, 32'(mon_err), 32'(ref_err));
    chk({tag, ".readdata"}, avl.readdata, ref_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [13];
    int          lat;
    logic [31:0] rd;
    logic [31:0] old;
    bit          wr;
    logic [8:0]  a;
    int          r;
    int          jat;

    tbl[0]  = '{1, 9'h010, 32'hA5A5A5A5, 4'b0011, 1, 32'h0,        2'b00};
    tbl[1]  = '{0, 9'h010, 32'h0,        4'hF,    0, 32'hFFFFA5A5, 2'b00};
    tbl[2]  = '{1, 9'h010, 32'h12345678, 4'b1100, 0, 32'hFFFFA5A5, 2'b00};
    tbl[3]  = '{0, 9'h010, 32'h0,        4'hF,    0, 32'hFFFFA5A5, 2'b00};
    tbl[4]  = '{1, 9'h010, 32'h12345678, 4'b1100, 1, 32'hFFFFA5A5, 2'b00};
    tbl[5]  = '{0, 9'h010, 32'h0,        4'hF,    0, 32'h1234A5A5, 2'b00};
    tbl[6]  = '{1, 9'h100, 32'h00000003, 4'hF,    0, 32'h1234A5A5, 2'b11};
    tbl[7]  = '{0, 9'h100, 32'h0,        4'hF,    0, 32'h00000003, 2'b11};
    tbl[8]  = '{0, 9'h101, 32'h0,        4'hF,    0, 32'h0,        2'b11};
    tbl[9]  = '{1, 9'h1FF, 32'hFFFFFFFF, 4'hF,    1, 32'h0,        2'b11};
    tbl[10] = '{0, 9'h1FF, 32'h0,        4'hF,    0, 32'h0,        2'b11};
    tbl[11] = '{1, 9'h100, 32'h00000000, 4'hF,    0, 32'h0,        2'b11};
    tbl[12] = '{0, 9'h100, 32'h0,        4'hF,    0, 32'h00000003, 2'b11};

    avl.address     = '0;
    avl.read        = 1'b0;
    avl.write       = 1'b0;
    avl.writedata   = '0;
    avl.byteenable  = '0;
    avl.debugaccess = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst.wait", 32'(avl.waitrequest), 32'd1);
    chk_outs("rst");
    reset_n = 1'b1;

    // fill the whole RAM so the model knows every word
    jtag_op(J_LOAD, 32'h0);
    for (int i = 0; i < 256; i++)
      jtag_op(J_WR, $urandom);

    // JTAG burst with address wrap
    jtag_op(J_LOAD, 32'hFE);
    jtag_op(J_WR, 32'h11111111);
    jtag_op(J_WR, 32'h22222222);
    jtag_op(J_RD, 32'h0);
    chk("wrap.rd_word0", mon_d, ref_mem[0]);
    jtag_op(J_LOAD, 32'hFE);
    jtag_op(J_RD, 32'h0);
    chk("burst.rd0", mon_d, 32'h11111111);
    jtag_op(J_RD, 32'h0);
    chk("burst.rd1", mon_d, 32'h22222222);

    // directed table
    jtag_op(J_LOAD, 32'h10);
    jtag_op(J_WR, 32'hFFFFFFFF);
    for (int i = 0; i < 13; i++) begin
      avl_op(tbl[i].wr, tbl[i].addr, tbl[i].wd,
             tbl[i].be, tbl[i].dbg, 0, 0, 32'h0,
             lat, rd);
      chk($sformatf("tbl%0d.lat", i), 32'(lat), 32'd3);
      chk($sformatf("tbl%0d.rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d.flags", i),
          32'({mon_err, mon_rdy}), 32'(tbl[i].exp_flags));
    end

    // JTAG load clears status flags
    jtag_op(J_LOAD, 32'h30);
    chk("clr.flags", 32'({mon_err, mon_rdy}), 32'd0);
    avl_op(0, 9'h100, 32'h0, 4'hF, 0, 0, 0, 32'h0, lat, rd);
    chk("clr.rd_status", rd, 32'h0);

    // contention: JTAG write in ACCESS, same word as CPU read
    avl_op(0, 9'h030, 32'h0, 4'hF, 0,
           J_WR, 2, 32'hDEADBEEF, lat, rd);
    chk("cont_w.lat", 32'(lat), 32'd4);
    chk("cont_w.rd", rd, 32'hDEADBEEF);
    // contention: JTAG read in ACCESS of a CPU write
    old = ref_mem[8'h31];
    avl_op(1, 9'h031, 32'h0BADF00D, 4'hF, 1,
           J_RD, 2, 32'h0, lat, rd);
    chk("cont_r.lat", 32'(lat), 32'd4);
    chk("cont_r.mond", mon_d, old);
    avl_op(0, 9'h031, 32'h0, 4'hF, 0, 0, 0, 32'h0, lat, rd);
    chk("cont_r.lat2", 32'(lat), 32'd3);
    chk("cont_r.rd", rd, 32'h0BADF00D);
    // collision while FSM idle
    avl_op(0, 9'h030, 32'h0, 4'hF, 0,
           J_RD, 1, 32'h0, lat, rd);
    chk("cont_i.lat", 32'(lat), 32'd4);
    chk("cont_i.rd", rd, 32'hDEADBEEF);
    chk_outs("cont_i");

    // reset asserted during ACCESS of a RAM write
    avl_op(1, 9'h100, 32'h3, 4'hF, 0, 0, 0, 32'h0, lat, rd);
    jtag_op(J_LOAD, 32'h20);
    jtag_op(J_WR, 32'hCAFEF00D);
    jtag_op(J_RD, 32'h0);
    @(negedge clk);
    avl.address     = 9'h020;
    avl.write       = 1'b1;
    avl.writedata   = 32'h0;
    avl.byteenable  = 4'hF;
    avl.debugaccess = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    ref_ptr   = 0;
    ref_rdy   = 1'b0;
    ref_err   = 1'b0;
    ref_mond  = '0;
    ref_rdata = '0;
    chk("rstmid.wait", 32'(avl.waitrequest), 32'd1);
    chk_outs("rstmid");
    @(negedge clk);
    avl.write = 1'b0;
    @(negedge clk);
    chk("rstmid.wait2", 32'(avl.waitrequest), 32'd1);
    reset_n = 1'b1;
    avl_op(0, 9'h020, 32'h0, 4'hF, 0, 0, 0, 32'h0, lat, rd);
    chk("rstmid.lat", 32'(lat), 32'd3);
    chk("rstmid.ram", rd, 32'hCAFEF00D);
    jtag_op(J_RD, 32'h0);
    chk("rstmid.ptr0", mon_d, ref_mem[0]);

    // random ops against the reference model
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        jtag_op(r, $urandom);
        chk_outs($sformatf("rnd%0d.j", n));
      end else begin
        wr = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r < 7) a = 9'($urandom_range(0, 255));
        else if (r < 9) a = 9'h100;
        else a = 9'($urandom_range(257, 511));
        jat = $urandom_range(0, 3);
        if (jat > 2) jat = 0;
        avl_op(wr, a, $urandom, 4'($urandom),
               1'($urandom_range(0, 3) != 0),
               $urandom_range(0, 2), jat, $urandom,
               lat, rd);
        chk($sformatf("rnd%0d.lat", n), 32'(lat),
            (jat != 0) ? 32'd4 : 32'd3);
        if (!wr) chk($sformatf("rnd%0d.rd", n), rd, ref_rdata);
        chk_outs($sformatf("rnd%0d.a", n));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
